// File: rtl/dme_pkg.sv
// dme_pkg: state encoding, synchroniser latency and X/Y channel timing constants (in microseconds)
// shared by the DME reply generator.
package dme_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_P2, DELAY, REPLY_P1, GAP, REPLY_P2, DEAD} state_t;
    localparam int SYNC_LAT           = 2;
    localparam int X_SPACING_US       = 12;
    localparam int X_DELAY_US         = 50;
    localparam int Y_SPACING_US       = 36;
    localparam int Y_DELAY_US         = 56;
    localparam int Y_REPLY_SPACING_US = 30;
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/dme_edge_sync.sv
// dme_edge_sync: two-flop synchroniser plus rising-edge strobe. A consumer acting on o_rise
// does so SYNC_LAT clk edges after the raw input was first sampled high.
module dme_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);
    logic r_meta, r_sync, r_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end
    assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/dme_reply_gen.sv
// dme_reply_gen: DME ground responder - validates an interrogation pulse pair and emits a delayed reply pair.
// Optional: define DME_MODE_Y_EN to add the mode_y input and Y-channel timing.
module dme_reply_gen
    import dme_pkg::*;
#(
    parameter int CYC_PER_US      = 100,
    parameter int PAIR_SPACING_US = X_SPACING_US,
    parameter int SPACING_TOL_US  = 1,
    parameter int REPLY_DELAY_US  = X_DELAY_US,
    parameter int PULSE_WIDTH_CYC = 350,
    parameter int DEAD_TIME_US    = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
`ifdef DME_MODE_Y_EN
    input  logic        mode_y,
`endif
    input  logic        rx_pulse,
    output logic        tx_pulse,
    output logic        reply_busy,
    output logic        decode_err,
    output logic [15:0] reply_count
);
    localparam int X_LO     = (PAIR_SPACING_US - SPACING_TOL_US) * CYC_PER_US;
    localparam int X_HI     = (PAIR_SPACING_US + SPACING_TOL_US) * CYC_PER_US;
    localparam int X_DLY    = REPLY_DELAY_US * CYC_PER_US;
    localparam int X_RSP    = PAIR_SPACING_US * CYC_PER_US;
    localparam int Y_LO     = (Y_SPACING_US - SPACING_TOL_US) * CYC_PER_US;
    localparam int Y_HI     = (Y_SPACING_US + SPACING_TOL_US) * CYC_PER_US;
    localparam int Y_DLY    = Y_DELAY_US * CYC_PER_US;
    localparam int Y_RSP    = Y_REPLY_SPACING_US * CYC_PER_US;
    localparam int DEAD_CYC = DEAD_TIME_US * CYC_PER_US;
    localparam int MAX_CYC  = max2(max2(max2(X_HI, X_DLY), max2(Y_HI, Y_DLY)),
                                   max2(max2(X_RSP, Y_RSP), max2(DEAD_CYC, PULSE_WIDTH_CYC)));
    localparam int CW       = $clog2(MAX_CYC) + 1;

    if (PULSE_WIDTH_CYC >= X_RSP || PULSE_WIDTH_CYC >= Y_RSP) begin : g_bad_width
        $error("PULSE_WIDTH_CYC must be shorter than the reply pair spacing");
    end

    state_t        r_state, w_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_now, w_sp, w_lo, w_hi, w_dly, w_rsp;
    logic          w_rise, w_err, w_inc, r_tx, r_err;
    logic [15:0]   r_count;

    dme_edge_sync u_sync (.clk(clk), .rst(rst), .i_async(rx_pulse), .o_rise(w_rise));

`ifdef DME_MODE_Y_EN
    logic r_mode_y;
    always_ff @(posedge clk) begin
        if (rst) r_mode_y <= 1'b0;
        else if (r_state == IDLE && w_nxt == WAIT_P2) r_mode_y <= mode_y;
    end
    assign w_lo  = r_mode_y ? CW'(Y_LO)  : CW'(X_LO);
    assign w_hi  = r_mode_y ? CW'(Y_HI)  : CW'(X_HI);
    assign w_dly = r_mode_y ? CW'(Y_DLY) : CW'(X_DLY);
    assign w_rsp = r_mode_y ? CW'(Y_RSP) : CW'(X_RSP);
`else
    assign w_lo  = CW'(X_LO);
    assign w_hi  = CW'(X_HI);
    assign w_dly = CW'(X_DLY);
    assign w_rsp = CW'(X_RSP);
`endif

    // r_cnt holds cycles elapsed since the reference edge; w_now is that count at the coming edge,
    // and w_sp strips the synchroniser delay to give the raw-input spacing of a strobe seen now.
    assign w_now = r_cnt + CW'(1);
    assign w_sp  = w_now - CW'(SYNC_LAT);

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = w_now;
        w_err     = 1'b0;
        w_inc     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise && enable) begin
                    w_nxt     = WAIT_P2;
                    w_cnt_nxt = CW'(SYNC_LAT);
                end
            end
            WAIT_P2: begin
                if (!enable) begin
                    w_nxt = IDLE;
                end else if (w_sp > w_hi) begin
                    w_nxt = IDLE;
                    w_err = 1'b1;
                end else if (w_rise) begin
                    w_nxt     = (w_sp < w_lo) ? WAIT_P2 : DELAY;
                    w_err     = (w_sp < w_lo);
                    w_cnt_nxt = CW'(SYNC_LAT);
                end
            end
            DELAY: begin
                if (w_now == w_dly) begin
                    w_nxt     = REPLY_P1;
                    w_cnt_nxt = '0;
                end
            end
            REPLY_P1: w_nxt = (w_now == CW'(PULSE_WIDTH_CYC)) ? GAP : REPLY_P1;
            GAP: begin
                if (w_now == w_rsp) begin
                    w_nxt     = REPLY_P2;
                    w_cnt_nxt = '0;
                end
            end
            REPLY_P2: begin
                if (w_now == CW'(PULSE_WIDTH_CYC)) begin
                    w_nxt     = DEAD;
                    w_cnt_nxt = '0;
                    w_inc     = 1'b1;
                end
            end
            DEAD: w_nxt = (w_now == CW'(DEAD_CYC)) ? IDLE : DEAD;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tx    <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= (w_nxt == REPLY_P1) || (w_nxt == REPLY_P2);
            r_err   <= w_err;
            r_count <= r_count + {15'd0, w_inc};
        end
    end

    assign tx_pulse    = r_tx;
    assign decode_err  = r_err;
    assign reply_count = r_count;
    assign reply_busy  = (r_state != IDLE) && (r_state != WAIT_P2);
endmodule
